// File: rtl/xdisplay.sv
// xdisplay: 4-digit multiplexed seven-segment display peripheral.
// The processor writes a 16-bit hex value plus four decimal-point bits; a
// free-running refresh counter scans the digits and drives active-low
// anode/segment/dp pins, all registered.
// Optional feature: define XDISPLAY_LZB_EN for leading-zero blanking.
module xdisplay #(
    parameter int REFRESH_W = 16,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_t;

    logic [15:0]          value_q, value_d;
    logic [3:0]           dp_r_q, dp_r_d;
    logic [REFRESH_W-1:0] cnt_q, cnt_d;
    dig_t                 dig_q, dig_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    logic [1:0] dig_idx;
    logic [3:0] nib;
    logic       blank;
    logic       unused_bits;

    assign dig_idx     = dig_q;
    assign nib         = value_q[{dig_idx, 2'b00} +: 4];
    assign unused_bits = ^data_in[DATA_W-1:20];

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hexdecode(input logic [3:0] h);
        case (h)
            4'h0: hexdecode = 7'h3F;
            4'h1: hexdecode = 7'h06;
            4'h2: hexdecode = 7'h5B;
            4'h3: hexdecode = 7'h4F;
            4'h4: hexdecode = 7'h66;
            4'h5: hexdecode = 7'h6D;
            4'h6: hexdecode = 7'h7D;
            4'h7: hexdecode = 7'h07;
            4'h8: hexdecode = 7'h7F;
            4'h9: hexdecode = 7'h6F;
            4'hA: hexdecode = 7'h77;
            4'hB: hexdecode = 7'h7C;
            4'hC: hexdecode = 7'h39;
            4'hD: hexdecode = 7'h5E;
            4'hE: hexdecode = 7'h79;
            default: hexdecode = 7'h71;
        endcase
    endfunction

`ifdef XDISPLAY_LZB_EN
    // A digit is blank when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        blank = 1'b0;
        case (dig_q)
            DIG3: blank = (value_q[15:12] == 4'h0);
            DIG2: blank = (value_q[15:8] == 8'h00);
            DIG1: blank = (value_q[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // Register load, refresh counter, scan advance and output pattern.
    always_comb begin
        value_d = value_q;
        dp_r_d  = dp_r_q;
        if (sel && we) begin
            value_d = data_in[15:0];
            dp_r_d  = data_in[19:16];
        end
        cnt_d = cnt_q + 1'b1;
        dig_d = dig_q;
        if (&cnt_q) begin
            case (dig_q)
                DIG0: dig_d = DIG1;
                DIG1: dig_d = DIG2;
                DIG2: dig_d = DIG3;
                default: dig_d = DIG0;
            endcase
        end
        an_d  = ~(4'b0001 << dig_idx);
        seg_d = blank ? 7'h7F : ~hexdecode(nib);
        dp_d  = ~dp_r_q[dig_idx];
    end

    // State register; reset wins over a concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            dp_r_q  <= '0;
            cnt_q   <= '0;
            dig_q   <= DIG0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            value_q <= value_d;
            dp_r_q  <= dp_r_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign data_out = DATA_W'({dp_r_q, value_q});
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_xdisplay.sv
// Directed self-checking bench for xdisplay with REFRESH_W=2.
module tb_xdisplay;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks   = 0;
    int failures = 0;

    xdisplay #(.REFRESH_W(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .data_in(data_in),
        .data_out(data_out), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) at negedges until an equals target.
    task automatic wait_an(input logic [3:0] target, input string tag);
        int n = 0;
        while (an !== target && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (an !== target) check({tag, "_timeout"}, {28'd0, an}, {28'd0, target});
    endtask

    task automatic write(input logic [31:0] d);
        sel = 1'b1; we = 1'b1; data_in = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; data_in = '0;
    endtask

    // Check one full frame starting at the first cycle of digit 0.
    task automatic scan(input string tag, input logic [6:0] s0, s1, s2, s3, input logic [3:0] dpv);
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        wait_an(4'b1101, {tag, "_pre"});
        wait_an(4'b1110, {tag, "_sync"});
        for (int i = 0; i < 16; i++) begin
            check({tag, "_an"}, {28'd0, an}, {28'd0, ~(4'b0001 << (i / 4))});
            if (i % 4 == 0) begin
                check({tag, "_seg"}, {25'd0, seg}, {25'd0, s[i/4]});
                check({tag, "_dp"}, {31'd0, dp}, {31'd0, ~dpv[i/4]});
            end
            @(negedge clk);
        end
        check({tag, "_wrap"}, {28'd0, an}, 32'h0000_000E);
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'h1);
        check("rst_data_out", data_out, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_an", {28'd0, an}, 32'hE);
        check("first_seg", {25'd0, seg}, 32'h40);

        // Write and scan
        write(32'h0001_1234);
        check("wr_data_out", data_out, 32'h0001_1234);
        scan("scan1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0001);

        // Write qualification
        sel = 1'b1; we = 1'b0; data_in = 32'h0000_FFFF;
        @(negedge clk);
        check("qual_we0", data_out, 32'h0001_1234);
        sel = 1'b0; we = 1'b1;
        @(negedge clk);
        check("qual_sel0", data_out, 32'h0001_1234);
        we = 1'b0; data_in = '0;

        // Hex range
        write(32'h0000_ABCD);
        check("wr_abcd", data_out, 32'h0000_ABCD);
        scan("scanABCD", ~7'h5E, ~7'h39, ~7'h7C, ~7'h77, 4'b0000);
        write(32'h000F_EF89);
        check("wr_ef89", data_out, 32'h000F_EF89);
        scan("scanEF89", ~7'h6F, ~7'h7F, ~7'h71, ~7'h79, 4'b1111);

        // Reset concurrent with a write while digit 2 is active
        wait_an(4'b1011, "midrst_sync");
        rst = 1'b1; sel = 1'b1; we = 1'b1; data_in = 32'h0000_5555;
        @(negedge clk);
        check("midrst_data_out", data_out, 32'h0);
        check("midrst_an", {28'd0, an}, 32'hF);
        rst = 1'b0; sel = 1'b0; we = 1'b0; data_in = '0;
        @(negedge clk);
        check("midrst_restart_an", {28'd0, an}, 32'hE);
        check("midrst_restart_seg", {25'd0, seg}, 32'h40);

        // Leading-zero blanking
        write(32'h0000_0050);
`ifdef XDISPLAY_LZB_EN
        scan("lzb0050", ~7'h3F, ~7'h6D, 7'h7F, 7'h7F, 4'b0000);
        write(32'h0000_0000);
        scan("lzb0000", ~7'h3F, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
`else
        scan("nolzb0050", ~7'h3F, ~7'h6D, ~7'h3F, ~7'h3F, 4'b0000);
        write(32'h0000_0000);
        scan("nolzb0000", ~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
